// File: rtl/control_sequencer.sv
// Multi-cycle microsequencer producing the datapath control word from IR0 and its T-state counter.
// Define CTRL_SEQ_JZ_EN to turn opcode 0 into a conditional jump (JZ a16) instead of NOP.

`ifndef OPCODEWORD_OPCODE_RANGE
`define OPCODEWORD_OPCODE_RANGE 7:5
`endif
`ifndef CB_ALU_OPCODE_RANGE
`define CB_ALU_OPCODE_RANGE 32:28
`endif
`ifndef CB_MID_RANGE
`define CB_MID_RANGE 27:22
`endif
`ifndef CB_SID_RANGE
`define CB_SID_RANGE 21:16
`endif
`ifndef CB_AMID_RANGE
`define CB_AMID_RANGE 15:14
`endif
`ifndef CB_MID_EN_RANGE
`define CB_MID_EN_RANGE 13
`endif
`ifndef CB_SID_EN_RANGE
`define CB_SID_EN_RANGE 12
`endif
`ifndef CB_PC_INR_RANGE
`define CB_PC_INR_RANGE 11
`endif
`ifndef CB_HLT_RANGE
`define CB_HLT_RANGE 10
`endif
`ifndef CB_CLR_TIMER_RANGE
`define CB_CLR_TIMER_RANGE 9
`endif

module control_sequencer #(
    parameter int CB_WIDTH      = 33,
    parameter int ZERO_FLAG_BIT = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                hlt,
    input  logic [7:0]          ir0,
    input  logic [3:0]          alu_status,
    output logic [CB_WIDTH-1:0] control_bus,
    output logic [2:0]          t_state,
    output logic                halted,
    output logic                instr_done
);

    typedef enum logic [1:0] {FETCH, EXEC, STALL, HALT} state_t;

    localparam logic [5:0] ID_IR0 = 6'd0;
    localparam logic [5:0] ID_A   = 6'd2;
    localparam logic [5:0] ID_B   = 6'd3;
    localparam logic [5:0] ID_M   = 6'd4;
    localparam logic [5:0] ID_AR0 = 6'd7;
    localparam logic [5:0] ID_AR1 = 6'd8;
    localparam logic [5:0] ID_PC0 = 6'd9;
    localparam logic [5:0] ID_PC1 = 6'd10;
    localparam logic [5:0] ID_ALU = 6'd18;
    localparam logic [1:0] AMID_PC = 2'd0;
    localparam logic [1:0] AMID_AR = 2'd1;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDA = 3'd1;
    localparam logic [2:0] OP_LDB = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_STA = 3'd5;
    localparam logic [2:0] OP_JMP = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    state_t        state, next_state;
    logic [2:0]    t_cnt, next_t;
    logic [2:0]    opcode;
    logic [5:0]    mid_f, sid_f;
    logic [1:0]    amid_f;
    logic          mv_en, pc_inr, hlt_f, last_step, halt_o;
    logic [CB_WIDTH-1:0] cb_word;
    logic          unused_inputs;

    assign opcode        = ir0[`OPCODEWORD_OPCODE_RANGE];
    assign unused_inputs = ^{ir0, alu_status, ZERO_FLAG_BIT[0]};

`ifdef CTRL_SEQ_JZ_EN
    logic zero_flag;
    assign zero_flag = alu_status[ZERO_FLAG_BIT];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            t_cnt <= '0;
        end else begin
            state <= next_state;
            t_cnt <= next_t;
        end
    end

    // HLT stays parked on T1; every other instruction returns to T0 after its last step.
    always_comb begin
        next_state = state;
        next_t     = t_cnt;
        case (state)
            FETCH, STALL: begin
                if (hlt) begin
                    next_state = STALL;
                    next_t     = 3'd0;
                end else begin
                    next_state = EXEC;
                    next_t     = 3'd1;
                end
            end
            EXEC: begin
                if (last_step) begin
                    next_state = FETCH;
                    next_t     = 3'd0;
                end else if (opcode == OP_HLT) begin
                    next_state = HALT;
                end else begin
                    next_t = t_cnt + 3'd1;
                end
            end
            HALT:    next_state = HALT;
            default: begin
                next_state = FETCH;
                next_t     = 3'd0;
            end
        endcase
    end

    // MID names the bus source and SID the destination of each transfer.
    always_comb begin
        mid_f     = '0;
        sid_f     = '0;
        amid_f    = AMID_PC;
        mv_en     = 1'b0;
        pc_inr    = 1'b0;
        hlt_f     = 1'b0;
        last_step = 1'b0;
        halt_o    = 1'b0;
        case (state)
            FETCH, STALL: begin
                if (!hlt) begin
                    mid_f  = ID_M;
                    sid_f  = ID_IR0;
                    mv_en  = 1'b1;
                    pc_inr = 1'b1;
                end
            end
            EXEC: begin
                case (opcode)
`ifdef CTRL_SEQ_JZ_EN
                    OP_NOP: begin
                        mv_en = 1'b1;
                        case (t_cnt)
                            3'd1: begin mid_f = ID_M;   sid_f = ID_AR0; pc_inr = 1'b1; end
                            3'd2: begin mid_f = ID_M;   sid_f = ID_AR1; pc_inr = 1'b1; last_step = !zero_flag; end
                            3'd3: begin mid_f = ID_AR0; sid_f = ID_PC0; end
                            default: begin mid_f = ID_AR1; sid_f = ID_PC1; last_step = 1'b1; end
                        endcase
                    end
`else
                    OP_NOP: last_step = 1'b1;
`endif
                    OP_LDA: begin
                        mid_f = ID_M; sid_f = ID_A; mv_en = 1'b1; pc_inr = 1'b1; last_step = 1'b1;
                    end
                    OP_LDB: begin
                        mid_f = ID_M; sid_f = ID_B; mv_en = 1'b1; pc_inr = 1'b1; last_step = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        mid_f = ID_ALU; sid_f = ID_A; mv_en = 1'b1; last_step = 1'b1;
                    end
                    OP_STA: begin
                        mv_en = 1'b1;
                        case (t_cnt)
                            3'd1: begin mid_f = ID_M; sid_f = ID_AR0; pc_inr = 1'b1; end
                            3'd2: begin mid_f = ID_M; sid_f = ID_AR1; pc_inr = 1'b1; end
                            default: begin amid_f = AMID_AR; mid_f = ID_A; sid_f = ID_M; last_step = 1'b1; end
                        endcase
                    end
                    OP_JMP: begin
                        mv_en = 1'b1;
                        case (t_cnt)
                            3'd1: begin mid_f = ID_M;   sid_f = ID_AR0; pc_inr = 1'b1; end
                            3'd2: begin mid_f = ID_M;   sid_f = ID_AR1; pc_inr = 1'b1; end
                            3'd3: begin mid_f = ID_AR0; sid_f = ID_PC0; end
                            default: begin mid_f = ID_AR1; sid_f = ID_PC1; last_step = 1'b1; end
                        endcase
                    end
                    default: begin
                        hlt_f  = 1'b1;
                        halt_o = 1'b1;
                    end
                endcase
            end
            HALT: begin
                hlt_f  = 1'b1;
                halt_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Holding reset low forces the whole word off, not just the state.
    always_comb begin
        cb_word = '0;
        cb_word[`CB_ALU_OPCODE_RANGE] = {2'b00, opcode};
        cb_word[`CB_MID_RANGE]        = mid_f;
        cb_word[`CB_SID_RANGE]        = sid_f;
        cb_word[`CB_AMID_RANGE]       = amid_f;
        cb_word[`CB_MID_EN_RANGE]     = mv_en;
        cb_word[`CB_SID_EN_RANGE]     = mv_en;
        cb_word[`CB_PC_INR_RANGE]     = pc_inr;
        cb_word[`CB_HLT_RANGE]        = hlt_f;
        cb_word[`CB_CLR_TIMER_RANGE]  = last_step;
        control_bus = reset ? cb_word : '0;
    end

    assign t_state    = t_cnt;
    assign halted     = reset & halt_o;
    assign instr_done = reset & last_step;

    a_t4_ends: assert property (@(posedge clk) disable iff (!reset)
        (state == EXEC && t_cnt == 3'd4) |-> last_step);
    a_no_pc_collision: assert property (@(posedge clk) disable iff (!reset)
        pc_inr |-> (sid_f != ID_PC0 && sid_f != ID_PC1));

endmodule
